// File: rtl/op_entry_pkg.sv
// Shared encodings for the operation-entry sequencer: FSM states, button indices, counter width.
// No logic; imported by op_entry_seq and btn_debounce.
// Debounce counting is enabled by defining OP_ENTRY_DEBOUNCE_EN.
package op_entry_pkg;

    typedef enum logic [1:0] {
        S_OP   = 2'd0,
        S_A    = 2'd1,
        S_B    = 2'd2,
        S_SHOW = 2'd3
    } state_t;

    localparam int BTN_COMMIT = 0;
    localparam int BTN_CANCEL = 1;
    localparam int CNT_W      = 16;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, optional stability counter (OP_ENTRY_DEBOUNCE_EN), press pulse.
// Latency raw edge -> press: DEBOUNCE_CYCLES+3 cycles with the macro defined, 3 cycles without.
// No backpressure; only an accepted 0->1 level change yields a one-cycle press.
module btn_debounce
    import op_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_cycles
        $error("btn_debounce: DEBOUNCE_CYCLES must be within 1..65535");
    end

    logic s1_q, s1_d, s2_q, s2_d;
    logic lvl_prev_q, lvl_prev_d;
    logic press_q, press_d;
    logic lvl;

`ifdef OP_ENTRY_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             deb_q, deb_d;

    // Count consecutive disagreeing cycles; any agreeing cycle restarts from zero.
    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (s2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            deb_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            deb_q <= deb_d;
        end
    end

    assign lvl = deb_q;
`else
    assign lvl = s2_q;
`endif

    always_comb begin
        s1_d       = btn_raw;
        s2_d       = s1_q;
        lvl_prev_d = lvl;
        press_d    = lvl & ~lvl_prev_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            lvl_prev_q <= 1'b0;
            press_q    <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            lvl_prev_q <= lvl_prev_d;
            press_q    <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/op_entry_seq.sv
// Switch-driven entry of op/opA/opB via commit/cancel buttons; valid pulses on a complete set.
// State/registers update one cycle after a button press pulse; valid is the first S_SHOW cycle.
// No backpressure; debounce depth set by DEBOUNCE_CYCLES when OP_ENTRY_DEBOUNCE_EN is defined.
module op_entry_seq
    import op_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw,
    input  logic [3:0] btn,
    input  logic [3:0] result,
    output logic [3:0] op,
    output logic [3:0] opA,
    output logic [3:0] opB,
    output logic       valid,
    output logic [1:0] state,
    output logic [3:0] led
);

    logic [3:0] sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    logic [3:0] op_q, op_d, opa_q, opa_d, opb_q, opb_d;
    logic       valid_q, valid_d;
    state_t     state_q, state_d;
    logic       commit_evt, cancel_evt;
    logic       unused_btn;

    assign unused_btn = ^btn[3:2];

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_commit (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn[BTN_COMMIT]),
        .press   (commit_evt)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cancel (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn[BTN_CANCEL]),
        .press   (cancel_evt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_s1_q <= '0;
            sw_s2_q <= '0;
            state_q <= S_OP;
            op_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sw_s1_q <= sw_s1_d;
            sw_s2_q <= sw_s2_d;
            state_q <= state_d;
            op_q    <= op_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            valid_q <= valid_d;
        end
    end

    // Cancel takes priority over a coincident commit and latches nothing.
    always_comb begin
        sw_s1_d = sw;
        sw_s2_d = sw_s1_q;
        state_d = state_q;
        op_d    = op_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        valid_d = 1'b0;
        if (cancel_evt) begin
            state_d = S_OP;
        end else if (commit_evt) begin
            unique case (state_q)
                S_OP: begin
                    op_d    = sw_s2_q;
                    state_d = S_A;
                end
                S_A: begin
                    opa_d   = sw_s2_q;
                    state_d = S_B;
                end
                S_B: begin
                    opb_d   = sw_s2_q;
                    state_d = S_SHOW;
                    valid_d = 1'b1;
                end
                S_SHOW: state_d = S_OP;
                default: state_d = S_OP;
            endcase
        end
    end

    always_comb begin
        led = (state_q == S_SHOW) ? result : sw_s2_q;
    end

    assign op    = op_q;
    assign opA   = opa_q;
    assign opB   = opb_q;
    assign valid = valid_q;
    assign state = state_q;

endmodule
